wb_port_arbiter: RTL and testbench

Round-robin writeback arbiter that shares the physical register file's `NUM_WB` execute write ports among `NUM_REQ` functional-unit result streams. It sits between the FU outputs and the register-file `exe_w_v_i`/`exe_addr_i`/`exe_data_i` inputs. Each stream has its own valid/ready handshake. Granted results are driven to the write ports from registers, so register-file write timing is decoupled from FU completion logic.

---
 rtl/wb_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
//
// Round-robin writeback arbiter. NUM_REQ functional-unit result streams
// compete for NUM_WB register-file write ports. Each cycle the candidates are
// scanned starting at the round-robin pointer (wrapping modulo NUM_REQ). The
// first min(#candidates, NUM_WB) candidates found are granted. The k-th grant
// in scan order drives write port k. Write-port outputs are registered.
//
// Build option (macro WB_PORT_ARBITER_SKID_EN):
//   defined   : one-entry skid buffer per stream. req_ready_o is "entry empty"
//               taken from a flop. Latency from acceptance to write port is 2.
//   undefined : no storage. req_ready_o is the combinational grant.
//               Latency is 1.
//
// Ports:
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   req_v_i     per-stream result valid
//   req_addr_i  per-stream destination physical register
//   req_data_i  per-stream result data
//   req_ready_o per-stream ready; a transfer completes on req_v_i & req_ready_o
//   wb_v_o      per-port write valid (registered)
//   wb_addr_o   per-port write address (registered, held when port idle)
//   wb_data_o   per-port write data (registered, held when port idle)
//   dup_err_o   sticky: two ports written to the same address in one cycle
// ----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_WB      = 2,
    parameter int PHYS_W      = 7,
    parameter int WORD_SIZE_P = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [NUM_REQ-1:0]                  req_v_i,
    input  logic [NUM_REQ-1:0][PHYS_W-1:0]      req_addr_i,
    input  logic [NUM_REQ-1:0][WORD_SIZE_P-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic [NUM_WB-1:0]                   wb_v_o,
    output logic [NUM_WB-1:0][PHYS_W-1:0]       wb_addr_o,
    output logic [NUM_WB-1:0][WORD_SIZE_P-1:0]  wb_data_o,
    output logic                                dup_err_o
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Candidate set and the address/data each candidate would write.
    logic [NUM_REQ-1:0]                  w_cand;
    logic [NUM_REQ-1:0][PHYS_W-1:0]      w_src_addr;
    logic [NUM_REQ-1:0][WORD_SIZE_P-1:0] w_src_data;

    // Arbitration results.
    logic [NUM_REQ-1:0]                  w_grant;
    logic [NUM_WB-1:0]                   w_port_v;
    logic [NUM_WB-1:0][RR_W-1:0]         w_port_sel;
    logic [NUM_WB-1:0][PHYS_W-1:0]       w_port_addr;
    logic [NUM_WB-1:0][WORD_SIZE_P-1:0]  w_port_data;
    logic [RR_W-1:0]                     w_last;
    logic [RR_W-1:0]                     w_rr_next;
    logic                                w_any;
    logic                                w_dup;

    logic [RR_W-1:0]                     r_rr;
    logic [NUM_WB-1:0]                   r_wb_v;
    logic [NUM_WB-1:0][PHYS_W-1:0]       r_wb_addr;
    logic [NUM_WB-1:0][WORD_SIZE_P-1:0]  r_wb_data;
    logic                                r_dup;

`ifdef WB_PORT_ARBITER_SKID_EN
    logic [NUM_REQ-1:0]                  r_skid_v;
    logic [NUM_REQ-1:0][PHYS_W-1:0]      r_skid_addr;
    logic [NUM_REQ-1:0][WORD_SIZE_P-1:0] r_skid_data;

    assign w_cand     = r_skid_v;
    assign w_src_addr = r_skid_addr;
    assign w_src_data = r_skid_data;
    // Ready is the registered "entry empty" state, forced low while in reset.
    assign req_ready_o = ~r_skid_v & {NUM_REQ{~reset_i}};

    // An entry that is full only drains; it refills at the earliest on the
    // following edge, so ready never depends on this cycle's grant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_skid_v <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_skid_v[i]) begin
                    if (w_grant[i]) begin
                        r_skid_v[i] <= 1'b0;
                    end
                end else if (req_v_i[i]) begin
                    r_skid_v[i] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only consumed behind r_skid_v.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!r_skid_v[i] && req_v_i[i]) begin
                r_skid_addr[i] <= req_addr_i[i];
                r_skid_data[i] <= req_data_i[i];
            end
        end
    end
`else
    assign w_cand     = req_v_i;
    assign w_src_addr = req_addr_i;
    assign w_src_data = req_data_i;
    assign req_ready_o = w_grant & {NUM_REQ{~reset_i}};
`endif

    // Scan from r_rr with wrap-around; grants fill ports 0,1,... in scan order.
    always_comb begin
        int cnt;
        int idx;
        w_grant    = '0;
        w_port_v   = '0;
        w_port_sel = '0;
        w_last     = '0;
        cnt        = 0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == idx) && w_cand[j] && (cnt < NUM_WB)) begin
                    w_grant[j] = 1'b1;
                    w_last     = RR_W'(j);
                    for (int p = 0; p < NUM_WB; p++) begin
                        if (p == cnt) begin
                            w_port_v[p]   = 1'b1;
                            w_port_sel[p] = RR_W'(j);
                        end
                    end
                    cnt = cnt + 1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            w_port_addr[p] = w_src_addr[w_port_sel[p]];
            w_port_data[p] = w_src_data[w_port_sel[p]];
        end
    end

    // Any two active ports targeting the same register this cycle.
    always_comb begin
        w_dup = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            for (int q = p + 1; q < NUM_WB; q++) begin
                if (w_port_v[p] && w_port_v[q] && (w_port_addr[p] == w_port_addr[q])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    assign w_any     = |w_grant;
    assign w_rr_next = (w_last == RR_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr      <= '0;
            r_wb_v    <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_dup     <= 1'b0;
        end else begin
            if (w_any) begin
                r_rr <= w_rr_next;
            end
            r_wb_v <= w_port_v;
            // Idle ports keep their last address/data.
            for (int p = 0; p < NUM_WB; p++) begin
                if (w_port_v[p]) begin
                    r_wb_addr[p] <= w_port_addr[p];
                    r_wb_data[p] <= w_port_data[p];
                end
            end
            if (w_dup) begin
                r_dup <= 1'b1;
            end
        end
    end

    assign wb_v_o    = r_wb_v;
    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign dup_err_o = r_dup;

endmodule

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_WB  = 2;
    localparam int PHYS_W  = 7;
    localparam int WS      = 16;
`ifdef WB_PORT_ARBITER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           reset;
    logic [NUM_REQ-1:0]             req_v;
    logic [NUM_REQ-1:0][PHYS_W-1:0] req_addr;
    logic [NUM_REQ-1:0][WS-1:0]     req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_WB-1:0]              wb_v;
    logic [NUM_WB-1:0][PHYS_W-1:0]  wb_addr;
    logic [NUM_WB-1:0][WS-1:0]      wb_data;
    logic                           dup_err;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_WB(NUM_WB), .PHYS_W(PHYS_W), .WORD_SIZE_P(WS)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_v_i(req_v), .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .wb_v_o(wb_v), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .dup_err_o(dup_err)
    );

    // Reference model: transaction-level view of arbitration state.
    int                             m_rr;
    logic [NUM_REQ-1:0]             m_sk_v;
    logic [PHYS_W-1:0]              m_sk_a [NUM_REQ];
    logic [WS-1:0]                  m_sk_d [NUM_REQ];
    logic [NUM_WB-1:0]              m_wb_v;
    logic [NUM_WB-1:0][PHYS_W-1:0]  m_wb_a;
    logic [NUM_WB-1:0][WS-1:0]      m_wb_d;
    logic                           m_dup;
    logic [NUM_REQ-1:0]             p_grant;
    logic [NUM_REQ-1:0]             p_ready;
    int                             p_ps [NUM_WB];
    int                             p_n;

    // Predict this cycle's grants and ready from the pending set.
    task automatic model_eval();
        int   order[$];
        int   s;
        logic pend;
        for (int k = 0; k < NUM_REQ; k++) begin
            s    = (m_rr + k) % NUM_REQ;
            pend = SKID ? m_sk_v[s] : req_v[s];
            if (pend === 1'b1) order.push_back(s);
        end
        p_n     = (order.size() < NUM_WB) ? order.size() : NUM_WB;
        p_grant = '0;
        for (int i = 0; i < p_n; i++) begin
            p_ps[i]           = order[i];
            p_grant[order[i]] = 1'b1;
        end
        if (reset)     p_ready = '0;
        else if (SKID) p_ready = ~m_sk_v;
        else           p_ready = p_grant;
    endtask

    // Apply the clock edge to the model.
    task automatic model_commit();
        if (reset) begin
            m_rr = 0; m_sk_v = '0; m_wb_v = '0; m_wb_a = '0; m_wb_d = '0; m_dup = 1'b0;
        end else begin
            m_wb_v = '0;
            for (int i = 0; i < p_n; i++) begin
                m_wb_v[i] = 1'b1;
                m_wb_a[i] = SKID ? m_sk_a[p_ps[i]] : req_addr[p_ps[i]];
                m_wb_d[i] = SKID ? m_sk_d[p_ps[i]] : req_data[p_ps[i]];
            end
            for (int i = 0; i < p_n; i++)
                for (int j = i + 1; j < p_n; j++)
                    if (m_wb_a[i] == m_wb_a[j]) m_dup = 1'b1;
            if (p_n > 0) m_rr = (p_ps[p_n-1] + 1) % NUM_REQ;
            if (SKID) begin
                for (int s = 0; s < NUM_REQ; s++) begin
                    if (m_sk_v[s]) begin
                        if (p_grant[s]) m_sk_v[s] = 1'b0;
                    end else if (req_v[s]) begin
                        m_sk_v[s] = 1'b1;
                        m_sk_a[s] = req_addr[s];
                        m_sk_d[s] = req_data[s];
                    end
                end
            end
        end
    endtask

    // One clock: inputs already applied; returns 1ns after the edge.
    task automatic step();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_v = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [NUM_REQ-1:0] exp_rdy;
        reset = 1'b1; req_v = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = PHYS_W'(10 + i);
            req_data[i] = WS'(16'hA000 + i);
        end
        step(); step();
        nchecks++; if (req_ready !== '0) begin nerr++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        nchecks++; if (wb_v !== '0) begin nerr++; $display("FAIL reset_wb_v: got %b want 0", wb_v); end
        nchecks++; if (wb_addr !== '0) begin nerr++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
        nchecks++; if (wb_data !== '0) begin nerr++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        nchecks++; if (dup_err !== 1'b0) begin nerr++; $display("FAIL reset_dup: got %b want 0", dup_err); end
        reset = 1'b0; #1;
        model_eval();
        exp_rdy = SKID ? 4'b1111 : 4'b0011;
        nchecks++; if (req_ready !== exp_rdy) begin nerr++; $display("FAIL first_ready: got %b want %b", req_ready, exp_rdy); end
        nchecks++; if (req_ready !== p_ready) begin nerr++; $display("FAIL first_ready_model: got %b want %b", req_ready, p_ready); end
        step();
`ifdef WB_PORT_ARBITER_SKID_EN
        nchecks++; if (wb_v !== '0) begin nerr++; $display("FAIL skid_lat: got %b want 00", wb_v); end
        step();
`endif
        nchecks++; if (wb_v !== 2'b11) begin nerr++; $display("FAIL first_wb_v: got %b want 11", wb_v); end
        nchecks++; if (wb_addr[0] !== 7'd10 || wb_addr[1] !== 7'd11) begin nerr++; $display("FAIL first_wb_addr: got %0d,%0d want 10,11", wb_addr[0], wb_addr[1]); end
        nchecks++; if (wb_data[0] !== 16'hA000 || wb_data[1] !== 16'hA001) begin nerr++; $display("FAIL first_wb_data: got %h,%h want a000,a001", wb_data[0], wb_data[1]); end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = PHYS_W'(20 + i);
            req_data[i] = WS'(16'h2000 + i);
        end
        req_v = '1; #1;
        for (int c = 0; c < 6; c++) begin
            step();
            nchecks++; if (wb_v !== m_wb_v || wb_addr !== m_wb_a || wb_data !== m_wb_d) begin
                nerr++; $display("FAIL rotation_model c=%0d: got v=%b a=%h want v=%b a=%h", c, wb_v, wb_addr, m_wb_v, m_wb_a);
            end
`ifndef WB_PORT_ARBITER_SKID_EN
            begin
                int first;
                first = (c % 2 == 0) ? 0 : 2;
                nchecks++; if (wb_v !== 2'b11 || wb_addr[0] !== PHYS_W'(20 + first) || wb_addr[1] !== PHYS_W'(21 + first)) begin
                    nerr++; $display("FAIL rotation c=%0d: got v=%b a0=%0d a1=%0d want 11,%0d,%0d", c, wb_v, wb_addr[0], wb_addr[1], 20 + first, 21 + first);
                end
            end
`endif
        end
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = PHYS_W'(30 + i);
            req_data[i] = WS'(16'h3000 + i);
        end
        req_v = 4'b0100; step();
        req_v = 4'b0101; step();
        nchecks++; if (wb_v !== m_wb_v || wb_addr !== m_wb_a || wb_data !== m_wb_d) begin
            nerr++; $display("FAIL sparse_model: got v=%b a=%h want v=%b a=%h", wb_v, wb_addr, m_wb_v, m_wb_a);
        end
`ifndef WB_PORT_ARBITER_SKID_EN
        nchecks++; if (wb_v !== 2'b11 || wb_addr[0] !== 7'd30 || wb_addr[1] !== 7'd32) begin
            nerr++; $display("FAIL sparse: got v=%b a0=%0d a1=%0d want 11,30,32", wb_v, wb_addr[0], wb_addr[1]);
        end
`endif
        req_v = '1; step();
        nchecks++; if (wb_v !== m_wb_v || wb_addr !== m_wb_a || wb_data !== m_wb_d) begin
            nerr++; $display("FAIL sparse_rr_model: got v=%b a=%h want v=%b a=%h", wb_v, wb_addr, m_wb_v, m_wb_a);
        end
`ifndef WB_PORT_ARBITER_SKID_EN
        nchecks++; if (wb_addr[0] !== 7'd33 || wb_addr[1] !== 7'd30) begin
            nerr++; $display("FAIL sparse_rr: got a0=%0d a1=%0d want 33,30", wb_addr[0], wb_addr[1]);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        req_addr[0] = 7'd1; req_addr[1] = 7'd2;
        req_data[0] = 16'h1111; req_data[1] = 16'h2222;
        req_v = 4'b0011; step();
        req_addr[1] = 7'd40; req_data[1] = 16'hBEEF;
        req_v = 4'b0010; step();
        nchecks++; if (wb_v !== m_wb_v || wb_addr !== m_wb_a || wb_data !== m_wb_d) begin
            nerr++; $display("FAIL single_model: got v=%b a=%h d=%h want v=%b a=%h d=%h", wb_v, wb_addr, wb_data, m_wb_v, m_wb_a, m_wb_d);
        end
`ifndef WB_PORT_ARBITER_SKID_EN
        nchecks++; if (wb_v !== 2'b01 || wb_addr[0] !== 7'd40 || wb_data[0] !== 16'hBEEF) begin
            nerr++; $display("FAIL single: got v=%b a0=%0d d0=%h want 01,40,beef", wb_v, wb_addr[0], wb_data[0]);
        end
        nchecks++; if (wb_addr[1] !== 7'd2 || wb_data[1] !== 16'h2222) begin
            nerr++; $display("FAIL single_hold: got a1=%0d d1=%h want 2,2222", wb_addr[1], wb_data[1]);
        end
`endif
    endtask

    task automatic test_dup();
        do_reset();
        req_addr[0] = 7'd5; req_addr[1] = 7'd5;
        req_data[0] = 16'h0505; req_data[1] = 16'h5050;
        req_v = 4'b0011; step();
`ifndef WB_PORT_ARBITER_SKID_EN
        nchecks++; if (dup_err !== 1'b1 || wb_v !== 2'b11) begin
            nerr++; $display("FAIL dup_set: got dup=%b v=%b want 1,11", dup_err, wb_v);
        end
`endif
        req_v = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            nchecks++; if (dup_err !== m_dup) begin nerr++; $display("FAIL dup_model c=%0d: got %b want %b", c, dup_err, m_dup); end
        end
        nchecks++; if (dup_err !== 1'b1) begin nerr++; $display("FAIL dup_sticky: got %b want 1", dup_err); end
        do_reset();
        nchecks++; if (dup_err !== 1'b0) begin nerr++; $display("FAIL dup_clear: got %b want 0", dup_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = PHYS_W'($urandom());
            req_data[i] = WS'($urandom());
        end
        req_v = '1; step();
        reset = 1'b1; #1;
        nchecks++; if (req_ready !== '0) begin nerr++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        step();
        nchecks++; if (wb_v !== '0) begin nerr++; $display("FAIL midrst_wb_v: got %b want 0", wb_v); end
        nchecks++; if (req_ready !== '0) begin nerr++; $display("FAIL midrst_ready2: got %b want 0", req_ready); end
        reset = 1'b0; req_v = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            nchecks++; if (wb_v !== '0) begin nerr++; $display("FAIL midrst_stale c=%0d: got %b want 0", c, wb_v); end
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] hold;
        do_reset();
        hold = '0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            for (int s = 0; s < NUM_REQ; s++) begin
                if (!hold[s]) begin
                    req_v[s]    = ($urandom_range(0, 3) != 0);
                    req_addr[s] = ($urandom_range(0, 3) == 0) ? PHYS_W'($urandom_range(0, 3)) : PHYS_W'($urandom());
                    req_data[s] = WS'($urandom());
                end
            end
            #1;
            model_eval();
            nchecks++; if (req_ready !== p_ready) begin nerr++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, p_ready); end
            step();
            hold = req_v & ~p_ready;
            nchecks++; if (wb_v !== m_wb_v) begin nerr++; $display("FAIL rand_wb_v c=%0d: got %b want %b", c, wb_v, m_wb_v); end
            nchecks++; if (wb_addr !== m_wb_a) begin nerr++; $display("FAIL rand_wb_addr c=%0d: got %h want %h", c, wb_addr, m_wb_a); end
            nchecks++; if (wb_data !== m_wb_d) begin nerr++; $display("FAIL rand_wb_data c=%0d: got %h want %h", c, wb_data, m_wb_d); end
            nchecks++; if (dup_err !== m_dup) begin nerr++; $display("FAIL rand_dup c=%0d: got %b want %b", c, dup_err, m_dup); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_v = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_rotation();
        test_sparse();
        test_single();
        test_dup();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
